// File: rtl/sd_cmd_host_if.sv
// Command/response handshake between the SD init/read sequencers
// and the SPI-mode command engine.
interface sd_cmd_host_if;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic        busy;
  logic        resp_valid;
  logic        resp_timeout;
  logic [39:0] resp_data;

  modport master (
    output cmd_start, cmd_index, cmd_arg, resp_long,
    input  busy, resp_valid, resp_timeout, resp_data
  );

  modport slave (
    input  cmd_start, cmd_index, cmd_arg, resp_long,
    output busy, resp_valid, resp_timeout, resp_data
  );
endinterface

// File: rtl/sd_cmd_host.sv
// SPI-mode SD host command engine: frames a command with CRC7,
// hunts for the card's response start bit and captures R1/R7.
module sd_cmd_host #(
  parameter int PRE_CYCLES  = 8,
  parameter int NCR_MAX     = 64,
  parameter int POST_CYCLES = 8
) (
  input  logic SD_CLK,
  input  logic rst,
  sd_cmd_host_if.slave bus,
  output logic SD_CS,
  output logic SD_OUT,
  input  logic SD_IN
);

  localparam int WW = $clog2(NCR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SEND, S_WAIT,
    S_RECV, S_POST, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] frame_q, frame_d;
  logic        long_q, long_d;
  logic        to_q, to_d;
  logic [5:0]  tx_q, tx_d;
  logic [5:0]  rx_q, rx_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [39:0] data_q, data_d;
  logic [39:0] hdr;

  function automatic logic [6:0] crc7(
    input logic [39:0] m
  );
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign hdr = {2'b01, bus.cmd_index, bus.cmd_arg};

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    long_d  = long_q;
    to_d    = to_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wait_d  = wait_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          frame_d = {hdr, crc7(hdr), 1'b1};
          long_d  = bus.resp_long;
          data_d  = '0;
          to_d    = 1'b0;
          tx_d    = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (tx_q == 6'(PRE_CYCLES - 1)) begin
          tx_d    = '0;
          state_d = S_SEND;
        end else begin
          tx_d = tx_q + 6'd1;
        end
      end
      S_SEND: begin
        frame_d = {frame_q[46:0], 1'b1};
        if (tx_q == 6'd47) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          tx_d = tx_q + 6'd1;
        end
      end
      S_WAIT: begin
        if (!SD_IN) begin
          data_d  = {data_q[38:0], SD_IN};
          rx_d    = long_q ? 6'd38 : 6'd6;
          state_d = S_RECV;
        end else if (wait_q == WW'(NCR_MAX - 1)) begin
          to_d    = 1'b1;
          tx_d    = '0;
          state_d = S_POST;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RECV: begin
        data_d = {data_q[38:0], SD_IN};
        if (rx_q == 6'd0) begin
          tx_d    = '0;
          state_d = S_POST;
        end else begin
          rx_d = rx_q - 6'd1;
        end
      end
      S_POST: begin
        if (tx_q == 6'(POST_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          tx_d = tx_q + 6'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      long_q  <= 1'b0;
      to_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      long_q  <= long_d;
      to_q    <= to_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    SD_CS  = (state_q == S_IDLE) ||
             (state_q == S_DONE);
    SD_OUT = (state_q == S_SEND) ? frame_q[47] : 1'b1;
  end

  assign bus.busy         = !SD_CS;
  assign bus.resp_valid   = (state_q == S_DONE) && !to_q;
  assign bus.resp_timeout = (state_q == S_DONE) && to_q;
  assign bus.resp_data    = data_q;

endmodule

// File: tb/tb_sd_cmd_host.sv
// Randomized scoreboard bench for sd_cmd_host with a
// behavioural SPI-mode SD card answering on the falling edge.
module tb_sd_cmd_host;
  logic clk = 1'b0;
  logic rst;
  logic SD_CS, SD_OUT, SD_IN;
  always #5 clk = ~clk;

  sd_cmd_host_if bus();

  sd_cmd_host dut (
    .SD_CLK(clk), .rst(rst), .bus(bus),
    .SD_CS(SD_CS), .SD_OUT(SD_OUT), .SD_IN(SD_IN)
  );

  typedef struct packed {
    logic        to;
    logic [39:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [47:0] fexp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ndone = 0;
  int last_bit_cyc = 0;
  int done_cyc = 0;
  logic [47:0] last_frame = '0;
  logic        card_ans = 1'b0;
  int          card_dly = 0;
  int          card_len = 8;
  logic [39:0] card_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [47:0] act,
                     input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Remainder of m(x)*x^7 by x^7+x^3+1, by long division
  function automatic logic [6:0] crc_model(
    input logic [39:0] m
  );
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] frame_model(
    input logic [5:0] idx, input logic [31:0] arg
  );
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc_model(m), 1'b1};
  endfunction

  task automatic send_cmd(input logic [5:0] idx,
                          input logic [31:0] arg,
                          input logic lng,
                          input logic ans,
                          input int dly,
                          input logic [39:0] rb);
    resp_t e;
    card_ans  = ans;
    card_dly  = dly;
    card_len  = lng ? 40 : 8;
    card_bits = rb;
    e.to   = !ans;
    e.data = !ans ? 40'h0 :
             (lng ? rb : {32'h0, rb[7:0]});
    exp_q.push_back(e);
    fexp_q.push_back(frame_model(idx, arg));
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_long = lng;
    bus.cmd_start = 1'b1;
    @(posedge clk);
    #1 bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int s;
    int n;
    s = ndone;
    n = 0;
    while (ndone == s && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ndone == s) begin
      failures++;
      $display("FAIL %s no response within 500 cycles",
               name);
    end
  endtask

  // Card model
  initial begin
    int mode;
    int nb;
    int dn;
    int bi;
    logic [47:0] fr;
    mode = 0; nb = 0; dn = 0; bi = 0; fr = '0;
    SD_IN = 1'b1;
    forever begin
      @(negedge clk);
      if (SD_CS) begin
        mode = 0;
        SD_IN = 1'b1;
      end else if (mode == 0) begin
        if (!SD_OUT) begin
          fr = '0;
          nb = 1;
          mode = 1;
        end
      end else if (mode == 1) begin
        fr = {fr[46:0], SD_OUT};
        nb++;
        if (nb == 48) begin
          last_frame = fr;
          last_bit_cyc = cyc;
          if (fexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame unexpected actual=%h", fr);
          end else begin
            chk("frame", fr, fexp_q.pop_front());
          end
          mode = 2;
          dn = 0;
          bi = 0;
        end
      end else if (mode == 2) begin
        if (!card_ans) begin
          SD_IN = 1'b1;
        end else if (dn < card_dly) begin
          SD_IN = 1'b1;
          dn++;
        end else begin
          SD_IN = card_bits[card_len - 1 - bi];
          bi++;
          if (bi == card_len) mode = 3;
        end
      end else begin
        SD_IN = 1'b1;
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (bus.resp_valid || bus.resp_timeout)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp unexpected actual=%h",
                   bus.resp_data);
        end else begin
          e = exp_q.pop_front();
          chk("resp_timeout", 48'(bus.resp_timeout),
              48'(e.to));
          chk("resp_valid", 48'(bus.resp_valid),
              48'(!e.to));
          chk("resp_data", 48'(bus.resp_data),
              48'(e.data));
          chk("busy_at_done", 48'(bus.busy), 48'h0);
        end
        done_cyc = cyc;
        ndone++;
      end
    end
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [39:0] r;
    logic lng;
    bus.cmd_start = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_long = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 48'(SD_CS), 48'h1);
    chk("rst_out", 48'(SD_OUT), 48'h1);
    chk("rst_busy", 48'(bus.busy), 48'h0);
    chk("rst_valid", 48'(bus.resp_valid), 48'h0);
    chk("rst_to", 48'(bus.resp_timeout), 48'h0);
    chk("rst_data", 48'(bus.resp_data), 48'h0);
    @(negedge clk);
    rst = 1'b0;

    // CMD0 with latency probe
    @(negedge clk);
    send_cmd(6'd0, 32'h0, 1'b0, 1'b1, 2, 40'h01);
    chk("busy_after_start", 48'(bus.busy), 48'h1);
    chk("cs_after_start", 48'(SD_CS), 48'h0);
    repeat (7) @(posedge clk);
    #1 chk("pre_last_out", 48'(SD_OUT), 48'h1);
    @(posedge clk);
    #1 chk("first_frame_bit", 48'(SD_OUT), 48'h0);
    wait_done("cmd0");
    chk("cmd0_frame", last_frame, 48'h400000000095);

    // CMD8 R7
    @(negedge clk);
    send_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 3,
             40'h01000001AA);
    wait_done("cmd8");
    chk("cmd8_crc", 48'(last_frame[7:0]), 48'h87);

    // CMD55 timeout
    @(negedge clk);
    send_cmd(6'd55, 32'h0, 1'b0, 1'b0, 0, 40'h0);
    wait_done("timeout");
    chk("timeout_cycles", 48'(done_cyc - last_bit_cyc),
        48'd73);

    // Start during SEND must be ignored
    @(negedge clk);
    send_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1, 40'h01);
    repeat (20) @(negedge clk);
    bus.cmd_index = 6'd17;
    bus.cmd_arg   = 32'hDEADBEEF;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    wait_done("ignored_start");
    s = ndone;
    repeat (150) @(negedge clk);
    chk("no_extra_resp", 48'(ndone), 48'(s));
    chk("idle_after_ignore", 48'(bus.busy), 48'h0);

    // Reset in the middle of an R7 capture
    @(negedge clk);
    send_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 2,
             40'h01000001AA);
    repeat (70) @(negedge clk);
    chk("busy_mid_recv", 48'(bus.busy), 48'h1);
    exp_q.delete();
    s = ndone;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs", 48'(SD_CS), 48'h1);
    chk("abort_out", 48'(SD_OUT), 48'h1);
    chk("abort_busy", 48'(bus.busy), 48'h0);
    chk("abort_valid", 48'(bus.resp_valid), 48'h0);
    chk("abort_to", 48'(bus.resp_timeout), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort_no_pulse", 48'(ndone), 48'(s));
    @(negedge clk);
    send_cmd(6'd0, 32'h0, 1'b0, 1'b1, 2, 40'h01);
    wait_done("cmd0_after_abort");

    // Back-to-back CMD55 then ACMD41
    @(negedge clk);
    send_cmd(6'd55, 32'h0, 1'b0, 1'b1, 1, 40'h01);
    wait_done("b2b_cmd55");
    @(posedge clk);
    #1;
    send_cmd(6'd41, 32'h40000000, 1'b0, 1'b1, 4,
             40'h00);
    chk("b2b_accepted", 48'(bus.busy), 48'h1);
    wait_done("b2b_acmd41");
    chk("acmd41_crc", 48'(last_frame[7:0]), 48'h77);

    // Randomized commands
    for (int i = 0; i < 10; i++) begin
      r = {8'($urandom), 32'($urandom)};
      lng = 1'($urandom_range(0, 1));
      if (lng) r[39] = 1'b0;
      else r[7] = 1'b0;
      @(negedge clk);
      send_cmd(6'($urandom_range(0, 63)), 32'($urandom),
               lng, $urandom_range(0, 3) != 0,
               $urandom_range(0, 20), r);
      wait_done("random");
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 48'(exp_q.size()), 48'h0);
    chk("frame_queue_empty", 48'(fexp_q.size()), 48'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
